// File: rtl/oq_read_scheduler.sv
// ---------------------------------------------------------------------------
// oq_read_scheduler
//
// Read-side scheduler for the SRAM output-queue memory. Sits between the
// write path (Axi2Fifo / AxiFifoArbiter), which reports each fully written
// packet, and the SRAM read controller, which streams one packet per grant.
//
// Each output queue has a counter of complete packets held in SRAM. A queue
// is eligible when its counter is nonzero and its downstream has room for a
// whole packet. Eligible queues are served round-robin, one packet at a time.
// A read request is held stable until the controller grants it. The scheduler
// then waits for the packet's last word before it arbitrates again.
//
// Optional feature (compile-time macro OQ_SCHED_Q0_PRIORITY_EN):
//   defined   - queue 0 wins whenever it is eligible and does not move the
//               round-robin pointer. Queues 1..NUM_QUEUES-1 rotate among
//               themselves.
//   undefined - plain round-robin over all queues.
//
// Ports:
//   memclk          in   scheduler clock (memory domain)
//   memreset        in   synchronous, active-high reset
//   pkt_commit      in   one complete packet written for pkt_commit_qid (pulse)
//   pkt_commit_qid  in   queue index of the committed packet
//   queue_ready     in   per-queue downstream has room for a full packet
//   rd_req          out  read request for the head packet of rd_qid
//   rd_qid          out  queue being read
//   rd_gnt          in   SRAM controller accepts rd_req
//   rd_done         in   last word of the granted packet has been read (pulse)
//   pkt_avail       out  bit q set when counter q is nonzero
//   busy            out  high while a request is pending or in flight
//   sched_err       out  sticky error flag (counter overflow, bad commit qid,
//                        rd_done with no packet in flight)
// ---------------------------------------------------------------------------
module oq_read_scheduler #(
    parameter int NUM_QUEUES = 5,
    parameter int QID_WIDTH  = 3,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  memclk,
    input  logic                  memreset,
    input  logic                  pkt_commit,
    input  logic [QID_WIDTH-1:0]  pkt_commit_qid,
    input  logic [NUM_QUEUES-1:0] queue_ready,
    output logic                  rd_req,
    output logic [QID_WIDTH-1:0]  rd_qid,
    input  logic                  rd_gnt,
    input  logic                  rd_done,
    output logic [NUM_QUEUES-1:0] pkt_avail,
    output logic                  busy,
    output logic                  sched_err
);

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        REQ       = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [QID_WIDTH:0]   NQ_EXT   = (QID_WIDTH+1)'(NUM_QUEUES);
    localparam logic [QID_WIDTH-1:0] LAST_QID = QID_WIDTH'(NUM_QUEUES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t                state;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  cnt      [NUM_QUEUES];
    logic [CNT_WIDTH-1:0]  cnt_next [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] ready_q;
    logic [QID_WIDTH-1:0]  rr_ptr;
    logic [QID_WIDTH-1:0]  rr_ptr_next;
    logic [QID_WIDTH-1:0]  rd_qid_next;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic                  commit_in_range;
    logic                  commit_valid;
    logic                  handshake;
    logic [NUM_QUEUES-1:0] inc_vec;
    logic [NUM_QUEUES-1:0] dec_vec;
    logic [NUM_QUEUES-1:0] avail_next;
    logic [NUM_QUEUES-1:0] eligible;
    logic                  sat_err;
    logic                  err_next;
    logic [QID_WIDTH:0]    idx_ext;
    logic [QID_WIDTH-1:0]  idx;
    logic                  rr_found;
    logic [QID_WIDTH-1:0]  rr_qid;

    assign rd_req    = (state == REQ);
    assign busy      = (state != ARB);
    assign handshake = rd_req && rd_gnt;

    assign commit_in_range = ({1'b0, pkt_commit_qid} < NQ_EXT);
    assign commit_valid    = pkt_commit && commit_in_range;

    // Per-queue increment and decrement strobes. A decrement can only match
    // the queue currently being read.
    always_comb begin
        // NOTE: every variable written here gets a default first, so that no
        // path leaves it unassigned and no latch is inferred.
        inc_vec = '0;
        dec_vec = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            inc_vec[q] = commit_valid && (pkt_commit_qid == QID_WIDTH'(q));
            dec_vec[q] = handshake && (rd_qid == QID_WIDTH'(q));
        end
    end

    // Counter update. A commit and a grant on the same queue in the same
    // cycle cancel. An increment at all-ones holds the count and flags an
    // error. The decrement guard keeps a stray grant from wrapping to max.
    always_comb begin
        sat_err    = 1'b0;
        avail_next = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            cnt_next[q] = cnt[q];
            if (inc_vec[q] && !dec_vec[q]) begin
                if (cnt[q] == CNT_MAX) begin
                    sat_err = 1'b1;
                end else begin
                    cnt_next[q] = cnt[q] + CNT_ONE;
                end
            end else if (dec_vec[q] && !inc_vec[q] && (cnt[q] != '0)) begin
                cnt_next[q] = cnt[q] - CNT_ONE;
            end
            avail_next[q] = (cnt_next[q] != '0);
        end
    end

    // Eligibility uses only registered inputs: the counters and a flopped
    // copy of queue_ready. A ready change therefore reaches the arbiter with
    // the same one-cycle delay as a commit.
    always_comb begin
        eligible = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            eligible[q] = (cnt[q] != '0) && ready_q[q];
        end
    end

    // Round-robin search starting after rr_ptr, wrapping modulo NUM_QUEUES.
    // rr_ptr is always below NUM_QUEUES, so one conditional subtract is
    // enough to wrap rr_ptr + i.
    always_comb begin
        rr_found = 1'b0;
        rr_qid   = '0;
        idx_ext  = '0;
        idx      = '0;
        for (int i = 1; i <= NUM_QUEUES; i++) begin
            idx_ext = {1'b0, rr_ptr} + (QID_WIDTH+1)'(i);
            if (idx_ext >= NQ_EXT) begin
                idx_ext = idx_ext - NQ_EXT;
            end
            idx = idx_ext[QID_WIDTH-1:0];
`ifdef OQ_SCHED_Q0_PRIORITY_EN
            // Queue 0 is handled by the priority path and never takes a
            // round-robin turn.
            if (!rr_found && eligible[idx] && (idx != '0)) begin
`else
            if (!rr_found && eligible[idx]) begin
`endif
                rr_found = 1'b1;
                rr_qid   = idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        rd_qid_next = rd_qid;
        rr_ptr_next = rr_ptr;
        unique case (state)
            ARB: begin
`ifdef OQ_SCHED_Q0_PRIORITY_EN
                if (eligible[0]) begin
                    rd_qid_next = '0;
                    state_next  = REQ;
                end else
`endif
                if (rr_found) begin
                    rd_qid_next = rr_qid;
                    rr_ptr_next = rr_qid;
                    state_next  = REQ;
                end
            end
            // The request stays up with a stable rd_qid until it is granted.
            // A drop in queue_ready does not withdraw it.
            REQ: begin
                if (rd_gnt) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rd_done) begin
                    state_next = ARB;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // Sticky error: overflow, out-of-range commit, or rd_done with no packet
    // in flight. rd_done outside WAIT_DONE has no other effect.
    assign err_next = sched_err
                   || sat_err
                   || (pkt_commit && !commit_in_range)
                   || (rd_done && (state != WAIT_DONE));

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge memclk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (memreset) begin
            state     <= ARB;
            rd_qid    <= '0;
            rr_ptr    <= LAST_QID;
            ready_q   <= '0;
            pkt_avail <= '0;
            sched_err <= 1'b0;
            // NOTE: the counter array is reset explicitly. It holds
            // architectural packet counts, so a stale value after reset would
            // issue reads for packets that do not exist.
            for (int q = 0; q < NUM_QUEUES; q++) begin
                cnt[q] <= '0;
            end
        end else begin
            state     <= state_next;
            rd_qid    <= rd_qid_next;
            rr_ptr    <= rr_ptr_next;
            ready_q   <= queue_ready;
            pkt_avail <= avail_next;
            sched_err <= err_next;
            for (int q = 0; q < NUM_QUEUES; q++) begin
                cnt[q] <= cnt_next[q];
            end
        end
    end

endmodule

// File: tb/tb_oq_read_scheduler.sv
// ---------------------------------------------------------------------------
// tb_oq_read_scheduler
//
// Directed testbench for oq_read_scheduler. The stimulus pushes the expected
// queue index of each grant into a scoreboard queue. A monitor running on the
// falling clock edge pops an entry and compares it on every rd_req/rd_gnt
// handshake. Latency, counter, pkt_avail and error-flag values are checked
// inline against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_oq_read_scheduler;

    localparam int NUM_QUEUES = 5;
    localparam int QID_WIDTH  = 3;
    localparam int CNT_WIDTH  = 8;

    logic                  memclk;
    logic                  memreset;
    logic                  pkt_commit;
    logic [QID_WIDTH-1:0]  pkt_commit_qid;
    logic [NUM_QUEUES-1:0] queue_ready;
    logic                  rd_req;
    logic [QID_WIDTH-1:0]  rd_qid;
    logic                  rd_gnt;
    logic                  rd_done;
    logic [NUM_QUEUES-1:0] pkt_avail;
    logic                  busy;
    logic                  sched_err;

    int vectors    = 0;
    int miscompares = 0;

    logic [QID_WIDTH-1:0] exp_q[$];

    oq_read_scheduler #(
        .NUM_QUEUES (NUM_QUEUES),
        .QID_WIDTH  (QID_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .memclk         (memclk),
        .memreset       (memreset),
        .pkt_commit     (pkt_commit),
        .pkt_commit_qid (pkt_commit_qid),
        .queue_ready    (queue_ready),
        .rd_req         (rd_req),
        .rd_qid         (rd_qid),
        .rd_gnt         (rd_gnt),
        .rd_done        (rd_done),
        .pkt_avail      (pkt_avail),
        .busy           (busy),
        .sched_err      (sched_err)
    );

    initial memclk = 1'b0;
    always #5 memclk = ~memclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: one handshake per granted packet.
    always @(negedge memclk) begin
        if (!memreset && rd_req && rd_gnt) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'(rd_qid), 32'hFFFF_FFFF);
            end else begin
                check("grant_qid", 32'(rd_qid), 32'(exp_q.pop_front()));
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge memclk);
        #1;
    endtask

    task automatic do_reset();
        memreset = 1'b1;
        step();
        step();
        memreset = 1'b0;
    endtask

    task automatic commit(input logic [QID_WIDTH-1:0] q);
        pkt_commit     = 1'b1;
        pkt_commit_qid = q;
        step();
        pkt_commit     = 1'b0;
    endtask

    task automatic pulse_done();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
    endtask

    // Serve n grants with rd_gnt high. rd_done is sampled 'delay' edges after
    // each grant edge. Between packets, expect one ARB cycle and then the next
    // request.
    task automatic serve(input int n, input int delay);
        bit ok;
        for (int i = 0; i < n; i++) begin
            ok = 1'b0;
            for (int c = 0; c < 50; c++) begin
                if (rd_req && rd_gnt) begin
                    ok = 1'b1;
                    break;
                end
                step();
            end
            if (!ok) begin
                check("grant_timeout", 32'(i), 32'(n));
                return;
            end
            step();
            check("req_drop_after_gnt", 32'(rd_req), 32'd0);
            repeat (delay - 1) step();
            pulse_done();
            if (i < n - 1) begin
                check("arb_gap_cycle", 32'(rd_req), 32'd0);
                step();
                check("b2b_req", 32'(rd_req), 32'd1);
            end
        end
    endtask

    initial begin
        bit seen;
        memreset       = 1'b1;
        pkt_commit     = 1'b0;
        pkt_commit_qid = '0;
        queue_ready    = '0;
        rd_gnt         = 1'b0;
        rd_done        = 1'b0;

        // ---- Reset values, single commit latency -------------------------
        queue_ready = 5'b11111;
        rd_gnt      = 1'b1;
        do_reset();
        check("rst_rd_req", 32'(rd_req), 32'd0);
        check("rst_rd_qid", 32'(rd_qid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_avail", 32'(pkt_avail), 32'd0);
        check("rst_sched_err", 32'(sched_err), 32'd0);

        commit(3'd2);
        check("lat_req_n1", 32'(rd_req), 32'd0);
        check("lat_avail_n1", 32'(pkt_avail), 32'b00100);
        exp_q.push_back(3'd2);
        step();
        check("lat_req_n2", 32'(rd_req), 32'd1);
        check("lat_qid_n2", 32'(rd_qid), 32'd2);
        step();
        check("gnt_req_low", 32'(rd_req), 32'd0);
        check("gnt_busy", 32'(busy), 32'd1);
        check("gnt_avail_cleared", 32'(pkt_avail), 32'd0);

        // A second packet arrives, but nothing is issued until rd_done.
        commit(3'd2);
        check("wait_avail", 32'(pkt_avail), 32'b00100);
        seen = 1'b0;
        repeat (5) begin
            step();
            if (rd_req) seen = 1'b1;
        end
        check("wait_done_no_req", 32'(seen), 32'd0);
        exp_q.push_back(3'd2);
        pulse_done();
        check("done_busy_low", 32'(busy), 32'd0);
        step();
        check("next_req", 32'(rd_req), 32'd1);
        step();
        pulse_done();

        // ---- Round-robin over queues 0,1,4 -------------------------------
        do_reset();
        queue_ready = '0;
        rd_gnt      = 1'b1;
        commit(3'd0); commit(3'd1); commit(3'd4);
        commit(3'd0); commit(3'd1); commit(3'd4);
        check("rr_avail_loaded", 32'(pkt_avail), 32'b10011);
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd4);
        exp_q.push_back(3'd0); exp_q.push_back(3'd1); exp_q.push_back(3'd4);
        queue_ready = 5'b11111;
        serve(6, 3);
        check("rr_avail_drained", 32'(pkt_avail), 32'd0);
        check("rr_busy_end", 32'(busy), 32'd0);
        check("rr_cnt4_zero", 32'(dut.cnt[4]), 32'd0);

        // ---- queue_ready gating on queue 3 -------------------------------
        rd_gnt      = 1'b0;
        queue_ready = 5'b10111;
        commit(3'd3);
        seen = 1'b0;
        repeat (20) begin
            step();
            if (rd_req) seen = 1'b1;
        end
        check("q3_blocked", 32'(seen), 32'd0);
        queue_ready = 5'b11111;
        step();
        check("q3_ready_n1", 32'(rd_req), 32'd0);
        step();
        check("q3_ready_n2", 32'(rd_req), 32'd1);
        check("q3_qid", 32'(rd_qid), 32'd3);
        queue_ready = 5'b10111;
        repeat (3) step();
        check("q3_req_held", 32'(rd_req), 32'd1);
        check("q3_qid_held", 32'(rd_qid), 32'd3);
        exp_q.push_back(3'd3);
        rd_gnt = 1'b1;
        step();
        rd_gnt = 1'b0;
        check("q3_after_gnt", 32'(rd_req), 32'd0);
        pulse_done();

        // ---- Same-cycle commit/grant, bad qid, stray rd_done -------------
        queue_ready = 5'b00010;
        commit(3'd1);
        step();
        check("q1_req", 32'(rd_req), 32'd1);
        check("q1_qid", 32'(rd_qid), 32'd1);
        exp_q.push_back(3'd1);
        pkt_commit     = 1'b1;
        pkt_commit_qid = 3'd1;
        rd_gnt         = 1'b1;
        step();
        pkt_commit = 1'b0;
        rd_gnt     = 1'b0;
        check("same_cycle_cnt1", 32'(dut.cnt[1]), 32'd1);
        check("same_cycle_avail", 32'(pkt_avail), 32'b00010);
        queue_ready = '0;
        pulse_done();
        check("q1_done_busy", 32'(busy), 32'd0);
        check("err_clear_before", 32'(sched_err), 32'd0);
        commit(3'd6);
        check("bad_qid_err", 32'(sched_err), 32'd1);
        check("bad_qid_ignored", 32'(pkt_avail), 32'b00010);
        pulse_done();
        check("stray_done_err", 32'(sched_err), 32'd1);
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_req", 32'(rd_req), 32'd0);

        // ---- Counter saturation, then reset during REQ -------------------
        do_reset();
        queue_ready    = '0;
        pkt_commit     = 1'b1;
        pkt_commit_qid = 3'd0;
        repeat (255) step();
        check("sat_cnt_255", 32'(dut.cnt[0]), 32'd255);
        check("sat_err_before", 32'(sched_err), 32'd0);
        step();
        pkt_commit = 1'b0;
        check("sat_cnt_hold", 32'(dut.cnt[0]), 32'd255);
        check("sat_err_set", 32'(sched_err), 32'd1);
        queue_ready = 5'b00001;
        step();
        step();
        check("pre_rst_req", 32'(rd_req), 32'd1);
        memreset = 1'b1;
        step();
        check("midrst_req", 32'(rd_req), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_avail", 32'(pkt_avail), 32'd0);
        check("midrst_cnt0", 32'(dut.cnt[0]), 32'd0);
        check("midrst_err", 32'(sched_err), 32'd0);
        memreset = 1'b0;

        // ---- Queue 0 priority vs plain round-robin -----------------------
        do_reset();
        queue_ready = '0;
        rd_gnt      = 1'b1;
        commit(3'd0); commit(3'd0); commit(3'd2); commit(3'd2);
`ifdef OQ_SCHED_Q0_PRIORITY_EN
        exp_q.push_back(3'd0); exp_q.push_back(3'd0);
        exp_q.push_back(3'd2); exp_q.push_back(3'd2);
`else
        exp_q.push_back(3'd0); exp_q.push_back(3'd2);
        exp_q.push_back(3'd0); exp_q.push_back(3'd2);
`endif
        queue_ready = 5'b11111;
        serve(4, 2);
        check("pri_avail_drained", 32'(pkt_avail), 32'd0);

        step();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
